// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state encoding and bus constants for the I2C target
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_DEV_ACK,
    ST_REG_ADDR,
    ST_REG_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_WAIT_STOP
  } i2c_tgt_state_t;

  localparam logic I2C_WR   = 1'b0;
  localparam logic I2C_RD   = 1'b1;
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  function automatic logic [7:0] addr_inc(input logic [7:0] a);
    return a + 8'd1;
  endfunction

endpackage

// File: rtl/i2c_target_sync_if.sv
// rtl/i2c_target_sync_if.sv - register port between the I2C target and a local register file
interface i2c_target_sync_if;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr_en;
  logic       reg_rd_en;
  logic [7:0] reg_rdata;

  modport master (
    output reg_addr, reg_wdata, reg_wr_en, reg_rd_en,
    input  reg_rdata
  );

  modport slave (
    input  reg_addr, reg_wdata, reg_wr_en, reg_rd_en,
    output reg_rdata
  );
endinterface

// File: rtl/i2c_bus_sync.sv
// rtl/i2c_bus_sync.sv - SCL/SDA synchronizers with edge, START and STOP pulses
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_s_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic                   scl_s;
  logic                   sda_s;

  // Left unreset on purpose: they only track the bus, and resetting them could fake a START.
  always_ff @(posedge clk) begin
    scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
    sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
    scl_prev_q <= scl_s;
    sda_prev_q <= sda_s;
  end

  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign sda_s_o    = sda_s;
  assign scl_rise_o = scl_s & ~scl_prev_q;
  assign scl_fall_o = ~scl_s & scl_prev_q;
  assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_target_sync.sv
// rtl/i2c_target_sync.sv - clock-synchronous I2C target exposing a simple register port
module i2c_target_sync
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      scl_i,
  input  logic                      sda_i,
  output logic                      sda_o,
  output logic                      busy,
  output logic                      txn_done,
  i2c_target_sync_if.master         rif
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_s_o    (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det)
  );

  i2c_tgt_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] rx_q, rx_d, tx_q, tx_d, addr_q, addr_d, wdata_q, wdata_d;
  logic       sda_q, sda_d, wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic       busy_q, busy_d, done_q, done_d, rw_q, rw_d, load_q, load_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    sda_d   = sda_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_en_d = 1'b0;
    rd_en_d = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rw_d    = rw_q;
    load_d  = 1'b0;
    // Read data arrives one clk after the strobe; the next SCL fall is many clks away.
    if (load_q) tx_d = rif.reg_rdata;
    if (stop_det) begin
      state_d = ST_IDLE;
      sda_d   = 1'b1;
      done_d  = busy_q;
      busy_d  = 1'b0;
    end else if (start_det) begin
      state_d = ST_DEV_ADDR;
      cnt_d   = 4'd0;
      sda_d   = 1'b1;
    end else if (scl_rise) begin
      case (state_q)
        ST_DEV_ADDR, ST_REG_ADDR, ST_WR_DATA: begin
          if (cnt_q < 4'd8) begin
            rx_d  = {rx_q[6:0], sda_s};
            cnt_d = cnt_q + 4'd1;
            if (state_q == ST_WR_DATA && cnt_q == 4'd7) begin
              wdata_d = rx_d;
              wr_en_d = 1'b1;
            end
          end
        end
        ST_REG_ACK: begin
          if (rw_q == I2C_RD) begin
            rd_en_d = 1'b1;
            load_d  = 1'b1;
          end
        end
        ST_RD_ACK: begin
          if (sda_s == I2C_ACK) begin
            addr_d  = addr_inc(addr_q);
            rd_en_d = 1'b1;
            load_d  = 1'b1;
          end else begin
            state_d = ST_WAIT_STOP;
          end
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      // Falls end one bit cell and start the next, so all SDA drive changes happen here.
      case (state_q)
        ST_DEV_ADDR: begin
          if (cnt_q == 4'd8) begin
            if (rx_q[7:1] == DEV_ADDR) begin
              state_d = ST_DEV_ACK;
              sda_d   = I2C_ACK;
              busy_d  = 1'b1;
              rw_d    = rx_q[0];
            end else begin
              state_d = ST_WAIT_STOP;
            end
          end
        end
        ST_DEV_ACK: begin
          state_d = ST_REG_ADDR;
          sda_d   = 1'b1;
          cnt_d   = 4'd0;
        end
        ST_REG_ADDR: begin
          if (cnt_q == 4'd8) begin
            state_d = ST_REG_ACK;
            addr_d  = rx_q;
            sda_d   = I2C_ACK;
          end
        end
        ST_WR_DATA: begin
          if (cnt_q == 4'd8) begin
            state_d = ST_WR_ACK;
            sda_d   = I2C_ACK;
          end
        end
        ST_WR_ACK: begin
          state_d = ST_WR_DATA;
          sda_d   = 1'b1;
          addr_d  = addr_inc(addr_q);
          cnt_d   = 4'd0;
        end
        ST_REG_ACK, ST_RD_ACK: begin
          if (state_q == ST_REG_ACK && rw_q == I2C_WR) begin
            state_d = ST_WR_DATA;
            sda_d   = 1'b1;
            cnt_d   = 4'd0;
          end else begin
            state_d = ST_RD_DATA;
            sda_d   = tx_q[7];
            tx_d    = {tx_q[6:0], 1'b1};
            cnt_d   = 4'd1;
          end
        end
        ST_RD_DATA: begin
          if (cnt_q == 4'd8) begin
            state_d = ST_RD_ACK;
            sda_d   = 1'b1;
          end else begin
            sda_d   = tx_q[7];
            tx_d    = {tx_q[6:0], 1'b1};
            cnt_d   = cnt_q + 4'd1;
          end
        end
        default: sda_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      rx_q    <= 8'd0;
      tx_q    <= 8'd0;
      sda_q   <= 1'b1;
      addr_q  <= 8'd0;
      wdata_q <= 8'd0;
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rw_q    <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      sda_q   <= sda_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_en_q <= wr_en_d;
      rd_en_q <= rd_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rw_q    <= rw_d;
      load_q  <= load_d;
    end
  end

  assign sda_o         = sda_q;
  assign busy          = busy_q;
  assign txn_done      = done_q;
  assign rif.reg_addr  = addr_q;
  assign rif.reg_wdata = wdata_q;
  assign rif.reg_wr_en = wr_en_q;
  assign rif.reg_rd_en = rd_en_q;

endmodule

// File: tb/tb_i2c_target_sync.sv
// tb/tb_i2c_target_sync.sv - directed I2C master stimulus with register-port scoreboard
module tb_i2c_target_sync;

  localparam int Q = 4;
  localparam int H = 8;
  localparam logic [1:0] EV_WR = 2'd0, EV_RD = 2'd1, EV_DONE = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] addr;
    logic [7:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic sda_o, busy, txn_done, sda_bus;
  logic [7:0] mem [256];
  ev_t exp_q[$];
  ev_t mon_got, mon_exp;
  int n_chk = 0;
  int n_fail = 0;
  int low_cnt = 0;

  i2c_target_sync_if rif();

  assign sda_bus       = sda_m & sda_o;
  assign rif.reg_rdata = mem[rif.reg_addr];

  i2c_target_sync #(.DEV_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (scl_m),
    .sda_i    (sda_bus),
    .sda_o    (sda_o),
    .busy     (busy),
    .txn_done (txn_done),
    .rif      (rif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] k, input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    e = {k, a, d};
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (sda_o == 1'b0) low_cnt++;
      if (rif.reg_wr_en || rif.reg_rd_en || txn_done) begin
        mon_got.kind = txn_done ? EV_DONE : (rif.reg_wr_en ? EV_WR : EV_RD);
        mon_got.addr = txn_done ? 8'h00 : rif.reg_addr;
        mon_got.data = rif.reg_wr_en ? rif.reg_wdata : 8'h00;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_event: got 0x%0h expected none", mon_got);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("reg_port_event", mon_got, mon_exp);
        end
      end
    end
  end

  task automatic wt(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; scl_m = 1'b1; wt(H);
    sda_m = 1'b0; wt(H);
    scl_m = 1'b0; wt(Q);
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; wt(Q);
    scl_m = 1'b1; wt(H);
    sda_m = 1'b1; wt(H);
  endtask

  task automatic wr_bit(input logic b);
    sda_m = b; wt(Q);
    scl_m = 1'b1; wt(H);
    scl_m = 1'b0; wt(Q);
  endtask

  task automatic rd_bit(output logic b);
    sda_m = 1'b1; wt(Q);
    scl_m = 1'b1; wt(H / 2);
    b = sda_bus; wt(H / 2);
    scl_m = 1'b0; wt(Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, input logic exp_ack, input string name);
    logic a;
    for (int i = 7; i >= 0; i--) wr_bit(d[i]);
    rd_bit(a);
    chk(name, {31'd0, a}, {31'd0, exp_ack});
  endtask

  task automatic rd_byte(output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rd_bit(b);
      d[i] = b;
    end
  endtask

  initial begin
    logic [7:0] rd;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h07] = 8'hC3;
    mem[8'h10] = 8'hA5;
    mem[8'h11] = 8'h3C;
    mem[8'h12] = 8'h81;
    wt(6);
    chk("rst_sda_o", {31'd0, sda_o}, 32'd1);
    chk("rst_reg_addr", {24'd0, rif.reg_addr}, 32'd0);
    chk("rst_reg_wdata", {24'd0, rif.reg_wdata}, 32'd0);
    chk("rst_wr_en", {31'd0, rif.reg_wr_en}, 32'd0);
    chk("rst_rd_en", {31'd0, rif.reg_rd_en}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_txn_done", {31'd0, txn_done}, 32'd0);
    rst = 1'b0;
    wt(4);

    // single write
    i2c_start;
    wr_byte(8'hA0, 1'b0, "t1_dev_ack");
    chk("t1_busy", {31'd0, busy}, 32'd1);
    wr_byte(8'h12, 1'b0, "t1_reg_ack");
    push(EV_WR, 8'h12, 8'h5A);
    wr_byte(8'h5A, 1'b0, "t1_data_ack");
    push(EV_DONE, 8'h00, 8'h00);
    i2c_stop;
    wt(4);
    chk("t1_busy_after", {31'd0, busy}, 32'd0);

    // single read, master NACK
    i2c_start;
    wr_byte(8'hA1, 1'b0, "t2_dev_ack");
    push(EV_RD, 8'h07, 8'h00);
    wr_byte(8'h07, 1'b0, "t2_reg_ack");
    rd_byte(rd);
    chk("t2_rd_data", {24'd0, rd}, 32'hC3);
    wr_bit(1'b1);
    push(EV_DONE, 8'h00, 8'h00);
    i2c_stop;
    wt(4);
    chk("t2_busy_after", {31'd0, busy}, 32'd0);

    // other device address
    low_cnt = 0;
    i2c_start;
    wr_byte(8'hA2, 1'b1, "t3_dev_nack");
    chk("t3_busy", {31'd0, busy}, 32'd0);
    wr_byte(8'h00, 1'b1, "t3_reg_nack");
    i2c_stop;
    wt(4);
    chk("t3_sda_never_low", low_cnt, 32'd0);

    // burst write across the address wrap
    i2c_start;
    wr_byte(8'hA0, 1'b0, "t4_dev_ack");
    wr_byte(8'hFF, 1'b0, "t4_reg_ack");
    push(EV_WR, 8'hFF, 8'h11);
    wr_byte(8'h11, 1'b0, "t4_d0_ack");
    push(EV_WR, 8'h00, 8'h22);
    wr_byte(8'h22, 1'b0, "t4_d1_ack");
    push(EV_DONE, 8'h00, 8'h00);
    i2c_stop;
    wt(4);

    // burst read ACK, ACK, NACK
    i2c_start;
    wr_byte(8'hA1, 1'b0, "t5_dev_ack");
    push(EV_RD, 8'h10, 8'h00);
    wr_byte(8'h10, 1'b0, "t5_reg_ack");
    rd_byte(rd);
    chk("t5_rd0", {24'd0, rd}, 32'hA5);
    push(EV_RD, 8'h11, 8'h00);
    wr_bit(1'b0);
    rd_byte(rd);
    chk("t5_rd1", {24'd0, rd}, 32'h3C);
    push(EV_RD, 8'h12, 8'h00);
    wr_bit(1'b0);
    rd_byte(rd);
    chk("t5_rd2", {24'd0, rd}, 32'h81);
    wr_bit(1'b1);
    push(EV_DONE, 8'h00, 8'h00);
    i2c_stop;
    wt(4);

    // reset in the middle of a data byte
    i2c_start;
    wr_byte(8'hA0, 1'b0, "t6_dev_ack");
    wr_byte(8'h20, 1'b0, "t6_reg_ack");
    wr_bit(1'b1); wr_bit(1'b0); wr_bit(1'b1); wr_bit(1'b1);
    rst = 1'b1;
    wt(1);
    chk("t6_rst_sda_o", {31'd0, sda_o}, 32'd1);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_reg_addr", {24'd0, rif.reg_addr}, 32'd0);
    wt(2);
    rst = 1'b0;
    sda_m = 1'b1; wt(Q);
    scl_m = 1'b1; wt(H);
    i2c_start;
    wr_byte(8'hA0, 1'b0, "t6_re_dev_ack");
    wr_byte(8'h30, 1'b0, "t6_re_reg_ack");
    push(EV_WR, 8'h30, 8'h77);
    wr_byte(8'h77, 1'b0, "t6_re_data_ack");
    push(EV_DONE, 8'h00, 8'h00);
    i2c_stop;
    wt(20);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
